pwm_tone_gen: RTL and testbench
===============================

Name: pwm_tone_gen

Overview:
Parametrised successor to the combinational frequency-to-PWM mapper. It accepts a tone frequency and a duty/volume word over a valid/ready handshake, and computes period = CLK_FREQ / freq with an iterative divider. The new settings take effect only at a PWM period boundary, so output is glitch-free. It sits between the note sequencer and the speaker pin.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz; must be < 2^CNT_WIDTH.
FREQ_WIDTH, 16, width of the freq input in Hz.
CNT_WIDTH, 32, width of the period counter and divider quotient.
DUTY_WIDTH, 8, width of the duty word; fraction = duty / 2^DUTY_WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
freq_valid  input  1  request strobe; freq and duty are valid.
freq_ready  output  1  block can accept a request (IDLE state).
freq  input  FREQ_WIDTH  tone frequency in Hz; 0 = mute.
duty  input  DUTY_WIDTH  duty/volume word.
pwm_out  output  1  registered PWM output.
period_out  output  CNT_WIDTH  currently active period in clocks; 0 when muted.
active  output  1  1 when a non-mute tone is active.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- Reset values: freq_ready=1, pwm_out=0, period_out=0, active=0. FSM=IDLE, counter=0, active duty count=0. Reset mid-divide or mid-pending abandons the request; nothing is committed.
- FSM states: IDLE, DIVIDE, SCALE, PENDING.
  - IDLE: freq_ready=1. On freq_valid&&freq_ready, capture freq and duty.
    - freq!=0 -> DIVIDE.
    - freq==0 -> PENDING with pending period=0 and pending duty count=0.
  - DIVIDE: restoring division of CLK_FREQ by the captured freq, one quotient bit per cycle, exactly CNT_WIDTH cycles, then -> SCALE.
  - SCALE: one cycle.
    - If quotient<2, pending period=2 (clamp); otherwise pending period=quotient.
    - pending duty count = (period*duty) >> DUTY_WIDTH, using a CNT_WIDTH+DUTY_WIDTH-bit product.
    - -> PENDING.
  - PENDING: wait for a boundary, then commit and -> IDLE.
    - Boundary = counter==active period-1, or active period==0 (mute, so commit on the first PENDING cycle).
    - Commit: the active period/duty registers load the pending values, and counter=0 on the next cycle.
- freq_ready=0 in every state except IDLE. freq_valid while not ready is ignored; no queuing.
- Latency for freq!=0: accept cycle, then CNT_WIDTH DIVIDE cycles, 1 SCALE cycle, then PENDING until the boundary.
- Counter:
  - Counts 0..period-1 and wraps to 0.
  - Held at 0 when active period==0.
  - pwm_out <= (counter < active duty count) && active period!=0, so pwm_out lags the counter by one register stage.
- period_out and active update in the commit cycle.
- Duty bounds: duty=0 gives constant 0. duty=2^DUTY_WIDTH-1 gives high for floor(period*255/256) clocks; 100% duty is never produced.
- A request identical to the active settings still runs the full flow and re-commits without disturbing the waveform phase beyond the boundary restart.
- Division remainder is discarded (floor).

Test Plan:
- Nominal tone: CLK_FREQ=1000, CNT_WIDTH=16, reset, freq=10, duty=128 handshake.
  - freq_ready low for 18 cycles: accept + 16 DIVIDE + SCALE, then PENDING commits immediately from mute.
  - Then period_out=100, active=1, pwm_out high 50 / low 50 clocks, repeating.
- Glitch-free update: while period=100, request freq=20, duty=64 mid-period.
  - Old 100-clock period completes unchanged.
  - Next period: period_out=50, high 12 clocks (50*64>>8), low 38.
- Mute: active tone, request freq=0.
  - Commit at the next boundary; then pwm_out=0, period_out=0, active=0, counter held 0.
  - A subsequent request commits on its first PENDING cycle.
- Clamp and duty extremes:
  - freq=600 (quotient 1) gives period_out=2.
  - freq=10 with duty=0 gives pwm_out constant 0.
  - freq=10 with duty=255 gives high 99 / low 1.
- Back-pressure: hold freq_valid=1 with freq=25 throughout a busy interval begun by freq=10.
  - Only freq=10 is committed first; freq=25 is accepted on the first IDLE cycle and then committed (period 40).
- Reset mid-operation:
  - Assert reset during DIVIDE: all outputs return to reset values the next cycle and no commit occurs.
  - Assert reset during an active tone: pwm_out=0 the next cycle.

Source files
------------

// File: rtl/pwm_tone_gen.sv
// Tone generator: divides CLK_FREQ by a requested frequency and drives a PWM
// output whose new period/duty take effect only at a period boundary.
module pwm_tone_gen #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned FREQ_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned DUTY_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freq_valid,
  output logic                  freq_ready,
  input  logic [FREQ_WIDTH-1:0] freq,
  input  logic [DUTY_WIDTH-1:0] duty,
  output logic                  pwm_out,
  output logic [CNT_WIDTH-1:0]  period_out,
  output logic                  active
);

  localparam int unsigned PW = CNT_WIDTH + DUTY_WIDTH;
  localparam int unsigned BW = $clog2(CNT_WIDTH + 1);
  localparam int unsigned RW = FREQ_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, SCALE, PENDING} state_t;

  state_t                state_q, state_d;
  logic [FREQ_WIDTH-1:0] divisor_q;
  logic [DUTY_WIDTH-1:0] duty_q;
  logic [CNT_WIDTH-1:0]  dvd_q;
  logic [FREQ_WIDTH-1:0] rem_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [CNT_WIDTH-1:0]  pend_period_q;
  logic [CNT_WIDTH-1:0]  pend_duty_q;
  logic [CNT_WIDTH-1:0]  act_duty_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  accept_c;
  logic                  commit_c;
  logic                  boundary_c;
  logic [RW-1:0]         rem_shift_c;
  logic                  sub_ok_c;
  logic [CNT_WIDTH-1:0]  period_c;
  logic [PW-1:0]         prod_c;
  logic [CNT_WIDTH-1:0]  duty_cnt_c;

  // Restoring-division step, period clamp and duty scaling
  always_comb begin
    rem_shift_c = {rem_q, dvd_q[CNT_WIDTH-1]};
    sub_ok_c    = rem_shift_c >= {1'b0, divisor_q};
    period_c    = (dvd_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : dvd_q;
    prod_c      = PW'(period_c) * PW'(duty_q);
    duty_cnt_c  = CNT_WIDTH'(prod_c >> DUTY_WIDTH);
    boundary_c  = (period_out == '0) || (cnt_q == period_out - CNT_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (freq_valid) begin
          accept_c = 1'b1;
          state_d  = (freq != '0) ? DIVIDE : PENDING;
        end
      end
      DIVIDE: begin
        if (bit_cnt_q == BW'(CNT_WIDTH - 1)) state_d = SCALE;
      end
      SCALE: state_d = PENDING;
      PENDING: begin
        if (boundary_c) begin
          commit_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, divider iteration and pending settings
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor_q     <= '0;
      duty_q        <= '0;
      dvd_q         <= '0;
      rem_q         <= '0;
      bit_cnt_q     <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            divisor_q     <= freq;
            duty_q        <= duty;
            dvd_q         <= CNT_WIDTH'(CLK_FREQ);
            rem_q         <= '0;
            bit_cnt_q     <= '0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
          end
        end
        DIVIDE: begin
          dvd_q     <= {dvd_q[CNT_WIDTH-2:0], sub_ok_c};
          rem_q     <= sub_ok_c ? FREQ_WIDTH'(rem_shift_c - {1'b0, divisor_q})
                                : FREQ_WIDTH'(rem_shift_c);
          bit_cnt_q <= bit_cnt_q + BW'(1);
        end
        SCALE: begin
          pend_period_q <= period_c;
          pend_duty_q   <= duty_cnt_c;
        end
        default: ;
      endcase
    end
  end

  // Active settings, period counter and PWM output
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_ready <= 1'b1;
      period_out <= '0;
      act_duty_q <= '0;
      active     <= 1'b0;
      cnt_q      <= '0;
      pwm_out    <= 1'b0;
    end else begin
      freq_ready <= (state_d == IDLE);
      pwm_out    <= (cnt_q < act_duty_q) && (period_out != '0);
      if (commit_c) begin
        period_out <= pend_period_q;
        act_duty_q <= pend_duty_q;
        active     <= (pend_period_q != '0);
        cnt_q      <= '0;
      end else if (period_out == '0 || cnt_q == period_out - CNT_WIDTH'(1)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_tone_gen.sv
// Directed bench for pwm_tone_gen with CLK_FREQ=1000, CNT_WIDTH=16.
module tb_pwm_tone_gen;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned FREQ_WIDTH = 16;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned DUTY_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  freq_valid;
  logic                  freq_ready;
  logic [FREQ_WIDTH-1:0] freq;
  logic [DUTY_WIDTH-1:0] duty;
  logic                  pwm_out;
  logic [CNT_WIDTH-1:0]  period_out;
  logic                  active;

  int checks   = 0;
  int failures = 0;

  pwm_tone_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .FREQ_WIDTH(FREQ_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .DUTY_WIDTH(DUTY_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .freq      (freq),
    .duty      (duty),
    .pwm_out   (pwm_out),
    .period_out(period_out),
    .active    (active)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Count high then low samples, starting on the first high sample of a period
  task automatic count_period(output int hi, output int lo);
    int t = 0;
    hi = 0;
    lo = 0;
    while (pwm_out === 1'b1 && t < 1000) begin hi++; t++; @(negedge clk); end
    while (pwm_out === 1'b0 && t < 1000) begin lo++; t++; @(negedge clk); end
    if (t >= 1000) hi = -1;
  endtask

  task automatic sync_rise();
    int t = 0;
    while (pwm_out !== 1'b0 && t < 1000) begin t++; @(negedge clk); end
    while (pwm_out !== 1'b1 && t < 1000) begin t++; @(negedge clk); end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (freq_ready !== 1'b1 && n < 500) begin n++; @(negedge clk); end
  endtask

  // Issue one request; caller is at a negedge with freq_ready high
  task automatic send(input logic [FREQ_WIDTH-1:0] f, input logic [DUTY_WIDTH-1:0] d);
    freq_valid = 1'b1;
    freq       = f;
    duty       = d;
    @(posedge clk);
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    freq_valid = 1'b0;
    freq       = '0;
    duty       = '0;
    repeat (3) @(negedge clk);
    checks++; if (freq_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", freq_ready); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%0b exp=0", pwm_out); end
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", active); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int n, hi, lo;
    send(16'd10, 8'd128);
    wait_ready(n);
    checks++; if (n != 18) begin failures++; $display("FAIL nominal_busy_cycles got=%0d exp=18", n); end
    checks++; if (period_out !== 16'd100) begin failures++; $display("FAIL nominal_period got=%0d exp=100", period_out); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL nominal_active got=%0b exp=1", active); end
    sync_rise();
    count_period(hi, lo);
    checks++; if (hi != 50) begin failures++; $display("FAIL nominal_high got=%0d exp=50", hi); end
    checks++; if (lo != 50) begin failures++; $display("FAIL nominal_low got=%0d exp=50", lo); end
  endtask

  task automatic test_update();
    int hi0, hi, lo, n;
    hi0 = (pwm_out === 1'b1) ? 1 : 0;
    send(16'd20, 8'd64);
    checks++; if (period_out !== 16'd100) begin failures++; $display("FAIL update_old_period got=%0d exp=100", period_out); end
    count_period(hi, lo);
    checks++; if (hi + hi0 != 50) begin failures++; $display("FAIL update_old_high got=%0d exp=50", hi + hi0); end
    checks++; if (lo != 50) begin failures++; $display("FAIL update_old_low got=%0d exp=50", lo); end
    checks++; if (period_out !== 16'd50) begin failures++; $display("FAIL update_new_period got=%0d exp=50", period_out); end
    count_period(hi, lo);
    checks++; if (hi != 12) begin failures++; $display("FAIL update_new_high got=%0d exp=12", hi); end
    checks++; if (lo != 38) begin failures++; $display("FAIL update_new_low got=%0d exp=38", lo); end
    wait_ready(n);
  endtask

  task automatic test_mute();
    int n = 0;
    int highs = 0;
    send(16'd0, 8'd128);
    while (active === 1'b1 && n < 500) begin n++; @(negedge clk); end
    checks++; if (n != 48) begin failures++; $display("FAIL mute_commit_delay got=%0d exp=48", n); end
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL mute_period got=%0d exp=0", period_out); end
    checks++; if (freq_ready !== 1'b1) begin failures++; $display("FAIL mute_ready got=%0b exp=1", freq_ready); end
    repeat (60) begin
      if (pwm_out !== 1'b0) highs++;
      @(negedge clk);
    end
    checks++; if (highs != 0) begin failures++; $display("FAIL mute_pwm_high_samples got=%0d exp=0", highs); end
  endtask

  task automatic test_clamp();
    int n, hi, lo;
    send(16'd600, 8'd128);
    wait_ready(n);
    checks++; if (n != 18) begin failures++; $display("FAIL clamp_busy_cycles got=%0d exp=18", n); end
    checks++; if (period_out !== 16'd2) begin failures++; $display("FAIL clamp_period got=%0d exp=2", period_out); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL clamp_active got=%0b exp=1", active); end
    sync_rise();
    count_period(hi, lo);
    checks++; if (hi != 1) begin failures++; $display("FAIL clamp_high got=%0d exp=1", hi); end
    checks++; if (lo != 1) begin failures++; $display("FAIL clamp_low got=%0d exp=1", lo); end
  endtask

  task automatic test_duty_extremes();
    int n, hi, lo;
    int highs = 0;
    send(16'd10, 8'd0);
    wait_ready(n);
    checks++; if (period_out !== 16'd100) begin failures++; $display("FAIL duty0_period got=%0d exp=100", period_out); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL duty0_active got=%0b exp=1", active); end
    repeat (250) begin
      if (pwm_out !== 1'b0) highs++;
      @(negedge clk);
    end
    checks++; if (highs != 0) begin failures++; $display("FAIL duty0_high_samples got=%0d exp=0", highs); end
    send(16'd10, 8'd255);
    wait_ready(n);
    sync_rise();
    count_period(hi, lo);
    checks++; if (hi != 99) begin failures++; $display("FAIL duty255_high got=%0d exp=99", hi); end
    checks++; if (lo != 1) begin failures++; $display("FAIL duty255_low got=%0d exp=1", lo); end
  endtask

  task automatic test_back_to_back();
    int n, hi, lo;
    freq_valid = 1'b1;
    freq       = 16'd10;
    duty       = 8'd128;
    @(posedge clk);
    @(negedge clk);
    freq = 16'd25;
    wait_ready(n);
    checks++; if (n >= 500) begin failures++; $display("FAIL b2b_ready_timeout got=%0d exp=<500", n); end
    checks++; if (period_out !== 16'd100) begin failures++; $display("FAIL b2b_first_period got=%0d exp=100", period_out); end
    @(posedge clk);
    @(negedge clk);
    freq_valid = 1'b0;
    checks++; if (freq_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%0b exp=0", freq_ready); end
    count_period(hi, lo);
    checks++; if (hi != 50) begin failures++; $display("FAIL b2b_first_high got=%0d exp=50", hi); end
    checks++; if (lo != 50) begin failures++; $display("FAIL b2b_first_low got=%0d exp=50", lo); end
    checks++; if (period_out !== 16'd40) begin failures++; $display("FAIL b2b_second_period got=%0d exp=40", period_out); end
    count_period(hi, lo);
    checks++; if (hi != 20) begin failures++; $display("FAIL b2b_second_high got=%0d exp=20", hi); end
    checks++; if (lo != 20) begin failures++; $display("FAIL b2b_second_low got=%0d exp=20", lo); end
  endtask

  task automatic test_reset_mid();
    int n;
    int highs = 0;
    send(16'd10, 8'd128);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (freq_ready !== 1'b1) begin failures++; $display("FAIL rstdiv_ready got=%0b exp=1", freq_ready); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rstdiv_pwm got=%0b exp=0", pwm_out); end
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL rstdiv_period got=%0d exp=0", period_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rstdiv_active got=%0b exp=0", active); end
    repeat (40) begin
      if (pwm_out !== 1'b0 || active !== 1'b0) highs++;
      @(negedge clk);
    end
    checks++; if (highs != 0) begin failures++; $display("FAIL rstdiv_no_commit got=%0d exp=0", highs); end
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL rstdiv_period_after got=%0d exp=0", period_out); end
    send(16'd10, 8'd255);
    wait_ready(n);
    sync_rise();
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL rsttone_pwm_before got=%0b exp=1", pwm_out); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rsttone_pwm got=%0b exp=0", pwm_out); end
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL rsttone_period got=%0d exp=0", period_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rsttone_active got=%0b exp=0", active); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_update();
    test_mute();
    test_clamp();
    test_duty_extremes();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
